// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port (ALU vs LSU) with a pending-write scoreboard.
// Define WB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over ALU.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_rd,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wreg_rd,
    output logic [XLEN-1:0] rf_wdata_rd,
    output logic [NREG-1:0] pending
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    logic            last_grant_reg;
    logic            rf_we_reg;
    logic [AW-1:0]   wreg_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;

    logic            lsu_wins;
    logic            xfer;
    logic            xfer_is_lsu;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    // lsu_wins only matters when both sources are requesting.
    always_comb begin
`ifdef WB_RR_EN
        lsu_wins = (last_grant_reg == GRANT_ALU);
`else
        lsu_wins = 1'b1 | last_grant_reg;
`endif
    end

    // Ready is withheld during reset so no source believes a dropped write was taken.
    assign alu_ready = rst_n & alu_valid & (~lsu_valid | ~lsu_wins);
    assign lsu_ready = rst_n & lsu_valid & (~alu_valid | lsu_wins);

    always_comb begin
        xfer        = alu_ready | lsu_ready;
        xfer_is_lsu = lsu_ready;
        win_rd      = lsu_ready ? lsu_rd   : alu_rd;
        win_data    = lsu_ready ? lsu_data : alu_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_reg      <= 1'b0;
            wreg_reg       <= '0;
            wdata_reg      <= '0;
            last_grant_reg <= GRANT_ALU;
        end else begin
            rf_we_reg <= 1'b0;
            if (xfer) begin
                last_grant_reg <= xfer_is_lsu ? GRANT_LSU : GRANT_ALU;
                // Writes to x0 are accepted but never reach the register file.
                if (win_rd != '0) begin
                    rf_we_reg <= 1'b1;
                    wreg_reg  <= win_rd;
                    wdata_reg <= win_data;
                end
            end
        end
    end

    // Per-register scoreboard next state; a same-cycle set beats the writeback clear.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pending
            if (gi == 0) begin : g_x0
                assign pending_next[gi] = 1'b0;
            end else begin : g_xn
                assign pending_next[gi] = (sb_set & (sb_rd == AW'(gi))) |
                                          (pending_reg[gi] & ~(rf_we_reg & (wreg_reg == AW'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign rf_we       = rf_we_reg;
    assign rf_wreg_rd  = wreg_reg;
    assign rf_wdata_rd = wdata_reg;
    assign pending     = pending_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios followed by randomized traffic.
// Build with +define+WB_RR_EN to check the round-robin variant.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            sb_set = 1'b0;
    logic [AW-1:0]   sb_rd = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_wreg_rd;
    logic [XLEN-1:0] rf_wdata_rd;
    logic [NREG-1:0] pending;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .sb_set(sb_set), .sb_rd(sb_rd),
        .rf_we(rf_we), .rf_wreg_rd(rf_wreg_rd), .rf_wdata_rd(rf_wdata_rd), .pending(pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int              due;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Reference state: which registers are outstanding, who was served last,
    // and the write that the register file is receiving this cycle.
    logic [NREG-1:0] exp_pend = '0;
    logic            model_last_lsu = 1'b0;
    logic            wb_now_valid = 1'b0;
    logic [AW-1:0]   wb_now_rd = '0;
    logic            checks_on = 1'b0;
    logic            a_hold = 1'b0;
    logic            l_hold = 1'b0;

    task automatic step(input logic rn,
                        input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                        input logic ss, input logic [AW-1:0] srd);
        logic ea, el, lsu_first;
        logic [AW-1:0] wrd;
        logic [XLEN-1:0] wdat;
        @(posedge clk);
        #1;
        rst_n = rn; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; sb_set = ss; sb_rd = srd;
        #3;
        ea = 1'b0;
        el = 1'b0;
        if (rn) begin
            if (av && lv) begin
`ifdef WB_RR_EN
                lsu_first = !model_last_lsu;
`else
                lsu_first = 1'b1;
`endif
                ea = !lsu_first;
                el = lsu_first;
            end else begin
                ea = av;
                el = lv;
            end
        end
        vectors++;
        if (alu_ready !== ea || lsu_ready !== el) begin
            miscompares++;
            $display("FAIL ready cyc=%0d got alu_ready=%b lsu_ready=%b want %b %b", cyc, alu_ready, lsu_ready, ea, el);
        end
        if (checks_on) begin
            vectors++;
            if (pending !== exp_pend) begin
                miscompares++;
                $display("FAIL pending cyc=%0d got %h want %h", cyc, pending, exp_pend);
            end
        end
        if (!rn) begin
            exp_pend = '0;
            model_last_lsu = 1'b0;
            wb_now_valid = 1'b0;
            checks_on = 1'b1;
        end else begin
            if (wb_now_valid) exp_pend[wb_now_rd] = 1'b0;
            if (ss && srd != 0) exp_pend[srd] = 1'b1;
            wb_now_valid = 1'b0;
            if (ea || el) begin
                wrd  = el ? lrd : ard;
                wdat = el ? ld : ad;
                model_last_lsu = el;
                if (wrd != 0) begin
                    exp_q.push_back('{cyc + 1, wrd, wdat});
                    wb_now_valid = 1'b1;
                    wb_now_rd = wrd;
                end
            end
        end
        a_hold = av && !ea;
        l_hold = lv && !el;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Monitor: every register-file write must match the oldest expected write, in its cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL lost_write cyc=%0d rd=%0d data=%h due=%0d got no rf_we", cyc, e.rd, e.data, e.due);
            end
            if (rf_we === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_write cyc=%0d got rd=%0d data=%h want none", cyc, rf_wreg_rd, rf_wdata_rd);
                end else begin
                    e = exp_q.pop_front();
                    if (e.due != cyc || rf_wreg_rd !== e.rd || rf_wdata_rd !== e.data) begin
                        miscompares++;
                        $display("FAIL write cyc=%0d got rd=%0d data=%h want rd=%0d data=%h due=%0d",
                                 cyc, rf_wreg_rd, rf_wdata_rd, e.rd, e.data, e.due);
                    end else begin
                        $display("wb cyc=%0d rd=%0d data=%h ok", cyc, rf_wreg_rd, rf_wdata_rd);
                    end
                end
            end else if (checks_on && rf_we !== 1'b0) begin
                vectors++;
                miscompares++;
                $display("FAIL rf_we_x cyc=%0d got %b want 0/1", cyc, rf_we);
            end
        end
    end

    initial begin
        logic rn, av, lv, ss;
        logic [AW-1:0] ard, lrd, srd;
        logic [XLEN-1:0] ad, ld;

        // Reset with both sources requesting: nothing may be accepted or written.
        repeat (2) step(1'b0, 1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b0, '0);
        idle(2);

        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0);
        idle(2);

        // Contention for four cycles.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 5'd1, 32'hA000_0001, 1'b1, 5'd2, 32'hB000_0000 + i, 1'b0, '0);
        idle(2);

        // x0 writeback is accepted and discarded.
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, '0);
        idle(2);

        // Scoreboard set then clear, then set colliding with the clearing write.
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        idle(1);
        step(1'b1, 1'b1, 5'd7, 32'h7777_0001, 1'b0, '0, '0, 1'b0, '0);
        idle(3);
        step(1'b1, 1'b1, 5'd7, 32'h7777_0002, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        idle(2);
        step(1'b1, 1'b1, 5'd7, 32'h7777_0003, 1'b0, '0, '0, 1'b0, '0);
        idle(2);

        // Back-to-back ALU burst, then reset lands mid-burst.
        step(1'b1, 1'b1, 5'd3, 32'h0000_0003, 1'b0, '0, '0, 1'b1, 5'd9);
        step(1'b1, 1'b1, 5'd4, 32'h0000_0004, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 5'd5, 32'h0000_0005, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 5'd6, 32'h0000_0006, 1'b0, '0, '0, 1'b0, '0);
        idle(3);

        // Randomized traffic; unaccepted requests are held stable.
        ard = '0; ad = '0; lrd = '0; ld = '0; av = 1'b0; lv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rn = ($urandom_range(99) != 0);
            if (!a_hold) begin
                av  = ($urandom_range(2) != 0);
                ard = AW'($urandom_range(31));
                ad  = $urandom;
            end
            if (!l_hold) begin
                lv  = ($urandom_range(2) != 0);
                lrd = AW'($urandom_range(31));
                ld  = $urandom;
            end
            ss  = ($urandom_range(3) == 0);
            srd = AW'($urandom_range(31));
            step(rn, av, ard, ad, lv, lrd, ld, ss, srd);
        end
        idle(4);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d writes outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
